z88_ps2_kbd: RTL and testbench

- Upstream feeder for the Blink keyboard port. Receives PS/2 (scan set 2) frames from a host keyboard and keeps a 64-bit Z88 key matrix image, kbmat, which drives the Blink kbmat input.
- Bit index = row*8 + col, where row = address line A8..A15 and col = data bit D0..D7; 1 = key pressed.
- Handles E0/F0/E1 prefixes, frame checking and glitch filtering.

---
 rtl/z88_ps2_kbd.sv | 261 ++++++++++++++++++++++++++
 tb/tb_z88_ps2_kbd.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z88_ps2_kbd.sv
// z88_ps2_kbd: PS/2 scan set 2 receiver maintaining the Z88 Blink key matrix.
// Optional KBD_BAT_CLEAR_EN: BAT/self-test bytes clear the whole matrix.
module z88_ps2_kbd #(
    parameter int FILT    = 8,
    parameter int TMO_CYC = 19661
) (
    input  logic        mck,
    input  logic        rin_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [63:0] kbmat,
    output logic        key_evt,
    output logic        frm_err,
    output logic [7:0]  rx_code
);
    localparam int FW = $clog2(FILT + 1);
    localparam int TW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {IDLE, RX, CHK} state_t;

    logic [1:0]    rst_q;
    logic          rst_n;
    logic [1:0]    clk_s;
    logic [1:0]    dat_s;
    logic          filt;
    logic [FW-1:0] fcnt;
    logic          edge_q;
    logic          bit_dat;

    state_t        state, state_nx;
    logic [3:0]    bitcnt, bitcnt_nx;
    logic [9:0]    sr, sr_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic          ext, ext_nx;
    logic          brk, brk_nx;
    logic [2:0]    skip, skip_nx;
    logic [63:0]   kbmat_nx;
    logic          key_evt_nx;
    logic          frm_err_nx;
    logic [7:0]    rx_code_nx;
    logic [7:0]    code;
    logic          good;
    logic [6:0]    hit;

    // Reset asserts immediately, releases two mck edges later.
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) rst_q <= 2'b00;
        else        rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n = rst_q[1];

    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            clk_s <= 2'b11;
            dat_s <= 2'b11;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_dat};
        end
    end

    // Filtered clock flips after FILT equal samples; a 1->0 flip is a bit edge.
    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            filt    <= 1'b1;
            fcnt    <= '0;
            edge_q  <= 1'b0;
            bit_dat <= 1'b1;
        end else begin
            edge_q <= 1'b0;
            if (clk_s[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILT - 1)) begin
                fcnt    <= '0;
                filt    <= clk_s[1];
                edge_q  <= filt;
                bit_dat <= dat_s[1];
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    function automatic logic [6:0] key_map(input logic [8:0] k);
        logic [6:0] r;
        r = '0;
        case (k)
            9'h05A: r = {1'b1, 6'd6};
            9'h066: r = {1'b1, 6'd7};
            9'h029: r = {1'b1, 6'd45};
            9'h01C: r = {1'b1, 6'd46};
            9'h012: r = {1'b1, 6'd54};
            9'h059: r = {1'b1, 6'd63};
            9'h076: r = {1'b1, 6'd61};
            9'h175: r = {1'b1, 6'd59};
            9'h172: r = {1'b1, 6'd58};
            9'h16B: r = {1'b1, 6'd57};
            9'h174: r = {1'b1, 6'd56};
            9'h016: r = {1'b1, 6'd0};
            9'h01E: r = {1'b1, 6'd1};
            9'h026: r = {1'b1, 6'd2};
            9'h025: r = {1'b1, 6'd3};
            9'h02E: r = {1'b1, 6'd4};
            9'h036: r = {1'b1, 6'd5};
            9'h03D: r = {1'b1, 6'd8};
            9'h03E: r = {1'b1, 6'd9};
            9'h046: r = {1'b1, 6'd10};
            9'h045: r = {1'b1, 6'd11};
            9'h015: r = {1'b1, 6'd12};
            9'h01D: r = {1'b1, 6'd13};
            9'h024: r = {1'b1, 6'd14};
            9'h02D: r = {1'b1, 6'd15};
            9'h02C: r = {1'b1, 6'd16};
            9'h035: r = {1'b1, 6'd17};
            9'h03C: r = {1'b1, 6'd18};
            9'h043: r = {1'b1, 6'd19};
            9'h044: r = {1'b1, 6'd20};
            9'h04D: r = {1'b1, 6'd21};
            9'h01B: r = {1'b1, 6'd22};
            9'h023: r = {1'b1, 6'd23};
            9'h02B: r = {1'b1, 6'd24};
            9'h034: r = {1'b1, 6'd25};
            9'h033: r = {1'b1, 6'd26};
            9'h03B: r = {1'b1, 6'd27};
            9'h042: r = {1'b1, 6'd28};
            9'h04B: r = {1'b1, 6'd29};
            9'h01A: r = {1'b1, 6'd30};
            9'h022: r = {1'b1, 6'd31};
            9'h021: r = {1'b1, 6'd32};
            9'h02A: r = {1'b1, 6'd33};
            9'h032: r = {1'b1, 6'd34};
            9'h031: r = {1'b1, 6'd35};
            9'h03A: r = {1'b1, 6'd36};
            9'h041: r = {1'b1, 6'd37};
            9'h049: r = {1'b1, 6'd38};
            9'h04A: r = {1'b1, 6'd39};
            9'h04C: r = {1'b1, 6'd40};
            9'h052: r = {1'b1, 6'd41};
            9'h054: r = {1'b1, 6'd42};
            9'h05B: r = {1'b1, 6'd43};
            9'h04E: r = {1'b1, 6'd44};
            9'h055: r = {1'b1, 6'd47};
            9'h05D: r = {1'b1, 6'd48};
            9'h00D: r = {1'b1, 6'd49};
            9'h058: r = {1'b1, 6'd50};
            9'h014: r = {1'b1, 6'd51};
            9'h011: r = {1'b1, 6'd52};
            9'h005: r = {1'b1, 6'd53};
            9'h006: r = {1'b1, 6'd55};
            9'h004: r = {1'b1, 6'd60};
            9'h00E: r = {1'b1, 6'd62};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Shift register fills LSB first: sr[7:0]=data, sr[8]=parity, sr[9]=stop.
    assign code = sr[7:0];
    assign good = (^sr[8:0]) && sr[9];
    assign hit  = key_map({ext, code});

    always_comb begin
        state_nx   = state;
        bitcnt_nx  = bitcnt;
        sr_nx      = sr;
        tmo_nx     = tmo;
        ext_nx     = ext;
        brk_nx     = brk;
        skip_nx    = skip;
        kbmat_nx   = kbmat;
        rx_code_nx = rx_code;
        frm_err_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (edge_q) begin
                    if (!bit_dat) begin
                        state_nx  = RX;
                        bitcnt_nx = 4'd1;
                        tmo_nx    = '0;
                    end else begin
                        frm_err_nx = 1'b1;
                    end
                end
            end
            RX: begin
                if (edge_q) begin
                    sr_nx  = {bit_dat, sr[9:1]};
                    tmo_nx = '0;
                    if (bitcnt == 4'd10) state_nx = CHK;
                    else bitcnt_nx = bitcnt + 4'd1;
                end else if (tmo == TW'(TMO_CYC - 1)) begin
                    state_nx   = IDLE;
                    frm_err_nx = 1'b1;
                    ext_nx     = 1'b0;
                    brk_nx     = 1'b0;
                end else begin
                    tmo_nx = tmo + 1'b1;
                end
            end
            CHK: begin
                state_nx = IDLE;
                if (!good) begin
                    frm_err_nx = 1'b1;
                    ext_nx     = 1'b0;
                    brk_nx     = 1'b0;
                end else begin
                    rx_code_nx = code;
                    if (skip != 3'd0) begin
                        skip_nx = skip - 3'd1;
                    end else if (code == 8'hE1) begin
                        skip_nx = 3'd7;
                    end else if (code == 8'hE0) begin
                        ext_nx = 1'b1;
                    end else if (code == 8'hF0) begin
                        brk_nx = 1'b1;
`ifdef KBD_BAT_CLEAR_EN
                    end else if (!ext && !brk &&
                                 (code == 8'hAA || code == 8'hFC ||
                                  code == 8'hFD)) begin
                        kbmat_nx = '0;
`endif
                    end else begin
                        if (hit[6]) kbmat_nx[hit[5:0]] = ~brk;
                        ext_nx = 1'b0;
                        brk_nx = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        key_evt_nx = (kbmat_nx != kbmat);
    end

    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bitcnt  <= '0;
            sr      <= '0;
            tmo     <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            skip    <= '0;
            kbmat   <= '0;
            key_evt <= 1'b0;
            frm_err <= 1'b0;
            rx_code <= '0;
        end else begin
            state   <= state_nx;
            bitcnt  <= bitcnt_nx;
            sr      <= sr_nx;
            tmo     <= tmo_nx;
            ext     <= ext_nx;
            brk     <= brk_nx;
            skip    <= skip_nx;
            kbmat   <= kbmat_nx;
            key_evt <= key_evt_nx;
            frm_err <= frm_err_nx;
            rx_code <= rx_code_nx;
        end
    end
endmodule

// File: tb/tb_z88_ps2_kbd.sv
// Bench for z88_ps2_kbd: table of directed frames, corner sequences,
// then random frames checked against a byte-level keyboard model.
module tb_z88_ps2_kbd;
    localparam int H   = 20;
    localparam int TMO = 3000;

    localparam logic [63:0] B6  = 64'h1 << 6;
    localparam logic [63:0] B7  = 64'h1 << 7;
    localparam logic [63:0] B46 = 64'h1 << 46;
    localparam logic [63:0] B54 = 64'h1 << 54;
    localparam logic [63:0] B57 = 64'h1 << 57;
    localparam logic [63:0] B59 = 64'h1 << 59;

    logic        mck = 1'b0;
    logic        rin_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [63:0] kbmat;
    logic        key_evt;
    logic        frm_err;
    logic [7:0]  rx_code;

    int checks = 0;
    int failures = 0;
    int evt_cnt = 0;
    int err_cnt = 0;

    logic [63:0] m_kb = '0;
    bit          m_ext = 0;
    bit          m_brk = 0;
    int          m_skip = 0;
    logic [7:0]  m_rx = '0;

    int          d_evt, d_err, x_evt, x_err;
    logic [63:0] lat_old, lat_new;

    typedef struct {
        logic [7:0]  code;
        bit          bad_par;
        bit          bad_stop;
        logic [63:0] kb;
        int          evt;
        int          err;
        logic [7:0]  rx;
    } vec_t;
    vec_t vecs[$];

    z88_ps2_kbd #(.FILT(8), .TMO_CYC(TMO)) dut (
        .mck     (mck),
        .rin_n   (rin_n),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .kbmat   (kbmat),
        .key_evt (key_evt),
        .frm_err (frm_err),
        .rx_code (rx_code)
    );

    always #5 mck = ~mck;

    always @(negedge mck) begin
        if (key_evt) evt_cnt++;
        if (frm_err) err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic int map_idx(input bit e, input logic [7:0] b);
        case ({e, b})
            9'h05A: return 6;
            9'h029: return 45;
            9'h01C: return 46;
            9'h012: return 54;
            9'h059: return 63;
            9'h076: return 61;
            9'h066: return 7;
            9'h175: return 59;
            9'h172: return 58;
            9'h16B: return 57;
            9'h174: return 56;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit ok);
        int idx;
        if (!ok) begin
            m_ext = 0;
            m_brk = 0;
        end else begin
            m_rx = b;
            if (m_skip > 0) m_skip--;
            else if (b == 8'hE1) m_skip = 7;
            else if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
`ifdef KBD_BAT_CLEAR_EN
            else if (!m_ext && !m_brk &&
                     (b == 8'hAA || b == 8'hFC || b == 8'hFD)) m_kb = '0;
`endif
            else begin
                idx = map_idx(m_ext, b);
                if (idx >= 0) m_kb[idx] = ~m_brk;
                m_ext = 0;
                m_brk = 0;
            end
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b,
                                               input bit bp, input bit bs);
        logic par;
        par = ~(^b) ^ bp;
        return {~bs, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n,
                             input bit lat);
        for (int i = 0; i < n; i++) begin
            @(negedge mck);
            ps2_dat = bits[i];
            repeat (H) @(negedge mck);
            ps2_clk = 1'b0;
            if (lat && i == 10) begin
                repeat (11) @(posedge mck);
                #1 check("latency pre", kbmat, lat_old);
                @(posedge mck);
                #1 check("latency kbmat", kbmat, lat_new);
                check("latency key_evt", 64'(key_evt),
                      64'(lat_new != lat_old));
                repeat (H - 12) @(negedge mck);
            end else begin
                repeat (H) @(negedge mck);
            end
            ps2_clk = 1'b1;
        end
        repeat (H) @(negedge mck);
        ps2_dat = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] b, input bit bp,
                             input bit bs, input bit lat);
        int e0, r0;
        logic [63:0] kb0;
        e0 = evt_cnt;
        r0 = err_cnt;
        kb0 = m_kb;
        model_byte(b, !(bp || bs));
        x_evt = (kb0 != m_kb) ? 1 : 0;
        x_err = (bp || bs) ? 1 : 0;
        lat_old = kb0;
        lat_new = m_kb;
        send_bits(frame_bits(b, bp, bs), 11, lat);
        d_evt = evt_cnt - e0;
        d_err = err_cnt - r0;
    endtask

    task automatic check_model(input string tag);
        check({tag, " kbmat"}, kbmat, m_kb);
        check({tag, " rx_code"}, 64'(rx_code), 64'(m_rx));
        check({tag, " key_evt"}, 64'(d_evt), 64'(x_evt));
        check({tag, " frm_err"}, 64'(d_err), 64'(x_err));
    endtask

    task automatic add(input logic [7:0] c, input bit bp, input bit bs,
                       input logic [63:0] kb, input int e, input int r,
                       input logic [7:0] rx);
        vec_t v;
        v.code = c;
        v.bad_par = bp;
        v.bad_stop = bs;
        v.kb = kb;
        v.evt = e;
        v.err = r;
        v.rx = rx;
        vecs.push_back(v);
    endtask

    initial begin
        int e0, r0, r, sel;
        logic [7:0] pool [11];
        logic [7:0] c;
        pool = '{8'h5A, 8'h29, 8'h1C, 8'h12, 8'h59, 8'h76,
                 8'h66, 8'h75, 8'h72, 8'h6B, 8'h74};

        add(8'h1C, 0, 0, B46, 1, 0, 8'h1C);
        add(8'hF0, 0, 0, B46, 0, 0, 8'hF0);
        add(8'h1C, 0, 0, 64'h0, 1, 0, 8'h1C);
        add(8'hE0, 0, 0, 64'h0, 0, 0, 8'hE0);
        add(8'h75, 0, 0, B59, 1, 0, 8'h75);
        add(8'hE0, 0, 0, B59, 0, 0, 8'hE0);
        add(8'hF0, 0, 0, B59, 0, 0, 8'hF0);
        add(8'h75, 0, 0, 64'h0, 1, 0, 8'h75);
        add(8'h75, 0, 0, 64'h0, 0, 0, 8'h75);
        add(8'h5A, 1, 0, 64'h0, 0, 1, 8'h75);
        add(8'hF0, 0, 1, 64'h0, 0, 1, 8'h75);
        add(8'h5A, 0, 0, B6, 1, 0, 8'h5A);
        add(8'hE0, 0, 0, B6, 0, 0, 8'hE0);
        add(8'h6B, 0, 0, B6 | B57, 1, 0, 8'h6B);
        add(8'hF0, 0, 0, B6 | B57, 0, 0, 8'hF0);
        add(8'hE0, 0, 0, B6 | B57, 0, 0, 8'hE0);
        add(8'h6B, 0, 0, B6, 1, 0, 8'h6B);
        add(8'h66, 0, 0, B6 | B7, 1, 0, 8'h66);
        add(8'hF0, 0, 0, B6 | B7, 0, 0, 8'hF0);
        add(8'h66, 0, 0, B6, 1, 0, 8'h66);
        add(8'hF0, 0, 0, B6, 0, 0, 8'hF0);
        add(8'h5A, 0, 0, 64'h0, 1, 0, 8'h5A);
        add(8'hF0, 0, 0, 64'h0, 0, 0, 8'hF0);
        add(8'h5A, 0, 0, 64'h0, 0, 0, 8'h5A);
        add(8'h12, 0, 0, B54, 1, 0, 8'h12);
        add(8'h1C, 0, 0, B54 | B46, 1, 0, 8'h1C);
        add(8'h1C, 0, 0, B54 | B46, 0, 0, 8'h1C);
        add(8'h1C, 0, 0, B54 | B46, 0, 0, 8'h1C);
        add(8'hE1, 0, 0, B54 | B46, 0, 0, 8'hE1);
        add(8'h14, 0, 0, B54 | B46, 0, 0, 8'h14);
        add(8'h77, 0, 0, B54 | B46, 0, 0, 8'h77);
        add(8'hE1, 0, 0, B54 | B46, 0, 0, 8'hE1);
        add(8'hF0, 0, 0, B54 | B46, 0, 0, 8'hF0);
        add(8'h14, 0, 0, B54 | B46, 0, 0, 8'h14);
        add(8'hF0, 0, 0, B54 | B46, 0, 0, 8'hF0);
        add(8'h77, 0, 0, B54 | B46, 0, 0, 8'h77);
`ifdef KBD_BAT_CLEAR_EN
        add(8'hAA, 0, 0, 64'h0, 1, 0, 8'hAA);
`else
        add(8'hAA, 0, 0, B54 | B46, 0, 0, 8'hAA);
`endif

        repeat (5) @(negedge mck);
        check("reset kbmat", kbmat, 64'h0);
        check("reset key_evt", 64'(key_evt), 64'h0);
        check("reset frm_err", 64'(frm_err), 64'h0);
        check("reset rx_code", 64'(rx_code), 64'h0);
        rin_n = 1'b1;
        repeat (10) @(negedge mck);

        foreach (vecs[i]) begin
            run_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, 0);
            check($sformatf("vec%0d kbmat", i), kbmat, vecs[i].kb);
            check($sformatf("vec%0d rx_code", i), 64'(rx_code),
                  64'(vecs[i].rx));
            check($sformatf("vec%0d key_evt", i), 64'(d_evt),
                  64'(vecs[i].evt));
            check($sformatf("vec%0d frm_err", i), 64'(d_err),
                  64'(vecs[i].err));
        end

        // Timeout with a break prefix pending: prefix must be dropped.
        run_frame(8'hF0, 0, 0, 0);
        check_model("tmo prefix");
        r0 = err_cnt;
        send_bits(frame_bits(8'h29, 0, 0), 4, 0);
        repeat (TMO - 300) @(negedge mck);
        check("tmo early", 64'(err_cnt - r0), 64'h0);
        repeat (600) @(negedge mck);
        check("tmo frm_err", 64'(err_cnt - r0), 64'h1);
        model_byte(8'h00, 0);
        run_frame(8'h29, 0, 0, 0);
        check_model("tmo after");

        // Short ps2_clk glitches while idle must not be taken as bits.
        e0 = evt_cnt;
        r0 = err_cnt;
        @(negedge mck);
        ps2_clk = 1'b0;
        repeat (3) @(negedge mck);
        ps2_clk = 1'b1;
        repeat (30) @(negedge mck);
        ps2_clk = 1'b0;
        repeat (7) @(negedge mck);
        ps2_clk = 1'b1;
        repeat (30) @(negedge mck);
        check("glitch frm_err", 64'(err_cnt - r0), 64'h0);
        check("glitch key_evt", 64'(evt_cnt - e0), 64'h0);
        run_frame(8'h76, 0, 0, 0);
        check_model("glitch after");

        run_frame(8'h59, 0, 0, 1);
        check_model("latency");

        // Reset in the middle of a frame.
        send_bits(frame_bits(8'h5A, 0, 0), 5, 0);
        @(negedge mck);
        rin_n = 1'b0;
        @(negedge mck);
        check("midrst kbmat", kbmat, 64'h0);
        check("midrst rx_code", 64'(rx_code), 64'h0);
        rin_n = 1'b1;
        m_kb = '0;
        m_ext = 0;
        m_brk = 0;
        m_skip = 0;
        m_rx = '0;
        repeat (10) @(negedge mck);
        run_frame(8'h1C, 0, 0, 0);
        check_model("midrst after");

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 19);
            sel = $urandom_range(0, 10);
            c = pool[sel];
            if (r <= 10)      run_frame(c, 0, 0, 0);
            else if (r <= 13) run_frame(8'hE0, 0, 0, 0);
            else if (r <= 16) run_frame(8'hF0, 0, 0, 0);
            else if (r == 17) run_frame(c, 1, 0, 0);
            else if (r == 18) run_frame(8'hE1, 0, 0, 0);
            else              run_frame(c, 0, 1, 0);
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
